// File: rtl/spi_master_param.sv
// Parametrised SPI master: all four CPOL/CPHA modes, multi-word bursts under one slave select.
// Latency: the first SCLK edge comes CLK_DIV+2 cycles after start is taken. rx_valid pulses one cycle after each
//          word's last edge. done pulses CLK_DIV+1 cycles after the final rx_valid.
// Backpressure: tx_ready is high only in LOAD. The burst pauses there with SCLK idle and ss_n held low until tx_valid.
// Ports: clk/reset; start, cpol, cpha, ss_sel, num_words form the burst request;
//        tx_data/tx_valid/tx_ready is the word input; rx_data/rx_valid is the word output;
//        busy/done give status; sclk/mosi/miso/ss_n are the SPI pins.
module spi_master_param #(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 4,
    parameter int NUM_SS    = 2,
    parameter int MAX_WORDS = 32,
    localparam int CNT_W    = $clog2(MAX_WORDS + 1),
    localparam int SS_W     = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [SS_W-1:0]   ss_sel,
    input  logic [CNT_W-1:0]  num_words,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_SS-1:0] ss_n
);

    localparam int DIV_W  = $clog2(CLK_DIV + 1);
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HOLD  = DIV_W'(CLK_DIV);
    localparam logic [EDGE_W-1:0] EDGES     = EDGE_W'(2 * DATA_W);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SETUP, SHIFT, HOLD} state_t;

    state_t              state, state_nxt;
    logic                mode_cpha, mode_cpha_nxt;
    logic [CNT_W-1:0]    words_left, words_left_nxt;
    logic [DIV_W-1:0]    div_cnt, div_cnt_nxt;
    logic [EDGE_W-1:0]   edge_cnt, edge_cnt_nxt;
    logic [DATA_W-1:0]   tx_sh, tx_sh_nxt;
    logic [DATA_W-1:0]   rx_sh, rx_sh_nxt;
    logic [DATA_W-1:0]   rx_data_nxt;
    logic                rx_valid_nxt, busy_nxt, done_nxt, sclk_nxt, mosi_nxt;
    logic [NUM_SS-1:0]   ss_n_nxt;
    logic                accept, leading;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mode_cpha  <= 1'b0;
            words_left <= '0;
            div_cnt    <= '0;
            edge_cnt   <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            ss_n       <= '1;
        end else begin
            state      <= state_nxt;
            mode_cpha  <= mode_cpha_nxt;
            words_left <= words_left_nxt;
            div_cnt    <= div_cnt_nxt;
            edge_cnt   <= edge_cnt_nxt;
            tx_sh      <= tx_sh_nxt;
            rx_sh      <= rx_sh_nxt;
            rx_data    <= rx_data_nxt;
            rx_valid   <= rx_valid_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            sclk       <= sclk_nxt;
            mosi       <= mosi_nxt;
            ss_n       <= ss_n_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        mode_cpha_nxt  = mode_cpha;
        words_left_nxt = words_left;
        div_cnt_nxt    = div_cnt;
        edge_cnt_nxt   = edge_cnt;
        tx_sh_nxt      = tx_sh;
        rx_sh_nxt      = rx_sh;
        rx_data_nxt    = rx_data;
        rx_valid_nxt   = 1'b0;
        busy_nxt       = busy;
        done_nxt       = 1'b0;
        sclk_nxt       = sclk;
        mosi_nxt       = mosi;
        ss_n_nxt       = ss_n;
        tx_ready       = (state == LOAD);
        leading        = ~edge_cnt[0];
        accept         = start && (num_words != '0) && (num_words <= CNT_W'(MAX_WORDS))
                         && ({1'b0, ss_sel} < (SS_W + 1)'(NUM_SS));

        case (state)
            IDLE: begin
                sclk_nxt = cpol;
                if (accept) begin
                    // The sclk register is the latched CPOL for the whole burst.
                    // An even number of edges per word always returns it to idle.
                    mode_cpha_nxt  = cpha;
                    words_left_nxt = num_words;
                    busy_nxt       = 1'b1;
                    ss_n_nxt       = ~(NUM_SS'(1) << ss_sel);
                    state_nxt      = LOAD;
                end
            end
            LOAD: begin
                if (tx_valid) begin
                    tx_sh_nxt    = tx_data;
                    if (!mode_cpha) begin
                        mosi_nxt = tx_data[DATA_W-1];
                    end
                    div_cnt_nxt  = '0;
                    edge_cnt_nxt = '0;
                    state_nxt    = SETUP;
                end
            end
            SETUP: begin
                if (div_cnt == DIV_LAST) begin
                    // Preload so that the first SHIFT cycle produces the leading edge.
                    div_cnt_nxt = DIV_LAST;
                    state_nxt   = SHIFT;
                end else begin
                    div_cnt_nxt = div_cnt + DIV_W'(1);
                end
            end
            SHIFT: begin
                if (edge_cnt == EDGES) begin
                    // The cycle after the last edge publishes the word.
                    rx_data_nxt    = rx_sh;
                    rx_valid_nxt   = 1'b1;
                    words_left_nxt = words_left - CNT_W'(1);
                    div_cnt_nxt    = '0;
                    state_nxt      = (words_left == CNT_W'(1)) ? HOLD : LOAD;
                end else if (div_cnt == DIV_LAST) begin
                    div_cnt_nxt  = '0;
                    edge_cnt_nxt = edge_cnt + EDGE_W'(1);
                    sclk_nxt     = ~sclk;
                    if (leading ^ mode_cpha) begin
                        rx_sh_nxt = {rx_sh[DATA_W-2:0], miso};
                    end else if (!(edge_cnt == EDGE_LAST && !mode_cpha)) begin
                        // With CPHA=0 the MSB went out at LOAD, so the next bit is one position down.
                        // The final trailing edge has nothing left to present.
                        mosi_nxt  = mode_cpha ? tx_sh[DATA_W-1] : tx_sh[DATA_W-2];
                        tx_sh_nxt = {tx_sh[DATA_W-2:0], 1'b0};
                    end
                end else begin
                    div_cnt_nxt = div_cnt + DIV_W'(1);
                end
            end
            HOLD: begin
                if (div_cnt == DIV_HOLD) begin
                    ss_n_nxt  = '1;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    div_cnt_nxt = div_cnt + DIV_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_master_param.sv
module tb_spi_master_param;
    localparam int DW = 8;
    localparam int DIV = 2;

    logic       clk, reset, start, cpol, cpha, tx_valid, tx_ready;
    logic [1:0] ss_sel;
    logic [5:0] num_words;
    logic [7:0] tx_data, rx_data;
    logic       rx_valid, busy, done, sclk, mosi, miso;
    logic [2:0] ss_n;

    spi_master_param #(.DATA_W(DW), .CLK_DIV(DIV), .NUM_SS(3), .MAX_WORDS(32)) dut (
        .clk(clk), .reset(reset), .start(start), .cpol(cpol), .cpha(cpha),
        .ss_sel(ss_sel), .num_words(num_words), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .done(done), .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int cyc_cnt = 0, t0 = 0, toggles = 0, first_edge_cyc = -1, last_rx_cyc = 0, done_cyc = 0;
    int done_seen = 0, rx_seen = 0;
    logic cpol_q = 1'b0, rst_q = 1'b1, m_prev_sclk = 1'b0;
    logic tb_cpol = 1'b0, tb_cpha = 1'b0, loopback = 1'b1;
    logic [1:0] exp_sel = 2'd0;
    logic [2:0] exp_ssn;
    logic [7:0] exp_rx[$];
    logic [7:0] slave_got[$];
    logic [7:0] burst_words [0:15];
    logic [7:0] slave_word = 8'h3C;
    logic [7:0] s_rx = 8'h00;
    logic [7:0] e_word;
    logic       slave_miso = 1'b0, s_prev = 1'b0;
    int         s_edge = 0;

    assign miso = loopback ? mosi : slave_miso;

    function void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        cpol_q  <= cpol;
        rst_q   <= reset;
    end

    // SPI slave: answers slave_word MSB first and collects what it receives on mosi.
    always @(negedge clk) begin
        if (reset || ss_n == 3'b111) begin
            s_edge = 0;
            slave_miso = slave_word[7];
        end else if (sclk != s_prev) begin
            s_edge++;
            if ((s_edge % 2 == 1) != tb_cpha) s_rx = {s_rx[6:0], mosi};
            else if (tb_cpha) slave_miso = slave_word[7 - (s_edge - 1) / 2];
            else if (s_edge < 16) slave_miso = slave_word[7 - s_edge / 2];
            if (s_edge == 16) begin
                slave_got.push_back(s_rx);
                s_edge = 0;
                if (!tb_cpha) slave_miso = slave_word[7];
            end
        end
        s_prev = sclk;
    end

    // Compare process: runs every cycle outside reset.
    always @(negedge clk) begin
        if (!reset && !rst_q) begin
            if (busy && sclk != m_prev_sclk) begin
                toggles++;
                if (first_edge_cyc < 0) first_edge_cyc = cyc_cnt;
            end
            if (rx_valid) begin
                chk("rx_valid_expected", exp_rx.size() > 0, 1);
                if (exp_rx.size() > 0) begin
                    e_word = exp_rx.pop_front();
                    chk("rx_data", rx_data, e_word);
                end
                rx_seen++;
                last_rx_cyc = cyc_cnt;
            end
            if (done) begin
                done_seen++;
                done_cyc = cyc_cnt;
            end
            if (!busy) begin
                chk("idle_sclk_tracks_cpol", sclk, cpol_q);
                chk("idle_ss_n", ss_n, 3'b111);
            end else begin
                exp_ssn = ~(3'b001 << exp_sel);
                chk("busy_ss_n", ss_n, exp_ssn);
                if (tx_ready) chk("load_sclk_at_cpol", sclk, tb_cpol);
            end
        end
        m_prev_sclk = sclk;
    end

    task automatic run_burst(input logic c_pol, input logic c_pha, input logic [1:0] sel, input int n,
                             input int stall_at, input bit mid_pulse, input bit loop, input int abort_rx);
        int idx = 0, stall = 0, cyc = 0, abort_wait = 0, d0, r0;
        bit hs;
        d0 = done_seen;
        r0 = rx_seen;
        loopback = loop; tb_cpol = c_pol; tb_cpha = c_pha; exp_sel = sel;
        exp_rx.delete();
        slave_got.delete();
        for (int i = 0; i < n; i++) exp_rx.push_back(loop ? burst_words[i] : slave_word);
        @(posedge clk); #1;
        cpol = c_pol; cpha = c_pha;
        repeat (2) @(posedge clk);
        #1;
        toggles = 0; first_edge_cyc = -1;
        start = 1; ss_sel = sel; num_words = 6'(n); tx_valid = 1; tx_data = burst_words[0];
        t0 = cyc_cnt + 1;
        @(posedge clk); #1;
        start = 0;
        while (done_seen == d0 && cyc < 4000) begin
            if (abort_rx >= 0 && rx_seen - r0 >= abort_rx) begin
                abort_wait++;
                if (abort_wait > 8) break;
            end
            if (mid_pulse && cyc == 10) begin
                start = 1; cpol = ~c_pol; cpha = ~c_pha;
                ss_sel = (sel == 2'd0) ? 2'd1 : 2'd0; num_words = 6'd3;
            end else begin
                start = 0; cpol = c_pol; cpha = c_pha; ss_sel = sel; num_words = 6'(n);
            end
            if (idx == stall_at && stall < 20) begin
                tx_valid = 0;
                if (tx_ready) stall++;
            end else if (idx < n) begin
                tx_valid = 1; tx_data = burst_words[idx];
            end else begin
                tx_valid = 0;
            end
            hs = tx_valid && tx_ready;
            @(posedge clk); #1;
            cyc++;
            if (hs) idx++;
        end
        start = 0; tx_valid = 0; cpol = c_pol; cpha = c_pha; ss_sel = sel;
        if (abort_rx >= 0) return;
        chk("done_within_budget", done_seen != d0, 1);
        repeat (6) @(posedge clk);
        #1;
        chk("done_pulses", done_seen - d0, 1);
        chk("rx_valid_pulses", rx_seen - r0, n);
        chk("sclk_toggles", toggles, 2 * DW * n);
        chk("rx_words_outstanding", exp_rx.size(), 0);
        if (!loop) begin
            chk("slave_word_count", slave_got.size(), n);
            for (int i = 0; i < n && i < slave_got.size(); i++) chk("slave_mosi_word", slave_got[i], burst_words[i]);
        end
    endtask

    task automatic try_bad_start(input logic [5:0] nw, input logic [1:0] sel);
        int d0;
        d0 = done_seen;
        @(posedge clk); #1;
        start = 1; num_words = nw; ss_sel = sel;
        @(posedge clk); #1;
        start = 0;
        @(negedge clk);
        chk("bad_start_busy", busy, 0);
        chk("bad_start_ss_n", ss_n, 3'b111);
        repeat (20) @(posedge clk);
        #1;
        chk("bad_start_no_done", done_seen - d0, 0);
    endtask

    int d0m, r0m;

    initial begin
        reset = 1; start = 0; cpol = 0; cpha = 0; ss_sel = 0; num_words = 0; tx_data = 0; tx_valid = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_ss_n", ss_n, 3'b111);
        reset = 0;
        repeat (2) @(posedge clk);

        // Mode 0, loopback, single word 0xA5; timing pinned by hand for CLK_DIV=2.
        burst_words[0] = 8'hA5;
        run_burst(1'b0, 1'b0, 2'd0, 1, -1, 1'b0, 1'b1, -1);
        chk("m0_rx_data", rx_data, 8'hA5);
        chk("m0_first_edge_delay", first_edge_cyc - t0, 4);
        chk("m0_rx_valid_delay", last_rx_cyc - t0, 35);
        chk("m0_done_delay", done_cyc - t0, 38);

        // Modes 1, 2, 3 against the slave model: master sends 0xC3, slave answers 0x3C.
        burst_words[0] = 8'hC3;
        run_burst(1'b0, 1'b1, 2'd0, 1, -1, 1'b0, 1'b0, -1);
        chk("m1_rx_data", rx_data, 8'h3C);
        run_burst(1'b1, 1'b0, 2'd1, 1, -1, 1'b0, 1'b0, -1);
        chk("m2_rx_data", rx_data, 8'h3C);
        run_burst(1'b1, 1'b1, 2'd0, 1, -1, 1'b0, 1'b0, -1);
        chk("m3_rx_data", rx_data, 8'h3C);

        // 16-byte key burst, 20-cycle stall before word 5, start pulsed while busy.
        for (int i = 0; i < 16; i++) burst_words[i] = 8'(i);
        run_burst(1'b0, 1'b0, 2'd0, 16, 4, 1'b1, 1'b1, -1);
        chk("burst_last_rx", rx_data, 8'h0F);

        // Highest slave select.
        burst_words[0] = 8'h5A;
        run_burst(1'b0, 1'b1, 2'd2, 1, -1, 1'b0, 1'b1, -1);
        chk("ss2_rx_data", rx_data, 8'h5A);

        // Reset in the middle of word 3 of a 4-word burst.
        burst_words[0] = 8'h11; burst_words[1] = 8'h22; burst_words[2] = 8'h33; burst_words[3] = 8'h44;
        run_burst(1'b0, 1'b0, 2'd0, 4, -1, 1'b0, 1'b1, 2);
        chk("pre_reset_busy", busy, 1);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("mid_rst_ss_n", ss_n, 3'b111);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sclk", sclk, 0);
        chk("mid_rst_mosi", mosi, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_rx_valid", rx_valid, 0);
        chk("mid_rst_rx_data", rx_data, 8'h00);
        reset = 0;
        exp_rx.delete();
        d0m = done_seen; r0m = rx_seen;
        repeat (40) @(posedge clk);
        #1;
        chk("post_rst_no_done", done_seen - d0m, 0);
        chk("post_rst_no_rx", rx_seen - r0m, 0);
        run_burst(1'b0, 1'b0, 2'd1, 4, -1, 1'b0, 1'b1, -1);
        chk("fresh_burst_rx", rx_data, 8'h44);

        // Requests that must be ignored.
        try_bad_start(6'd0, 2'd0);
        try_bad_start(6'd1, 2'd3);
        try_bad_start(6'd33, 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got no end, expected end");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

endmodule

// File: doc/spi_master_param.md
# spi_master_param

Parametrised SPI master for the AES system's SPI link. It generalises the fixed master with configurable word width, clock divider and slave-select count, and adds all four CPOL/CPHA modes. It also supports multi-word bursts under one chip-select, driven by a valid/ready transmit handshake with received words returned per word. It sits between the AES key/data path (burst producer/consumer) and the board SPI pins.

## Interface
Parameters:
- DATA_W, 8, bits per SPI word, MSB first
- CLK_DIV, 4, clk cycles per SCLK half-period (>=2)
- NUM_SS, 2, number of active-low slave selects
- MAX_WORDS, 32, maximum burst length (32 bytes = AES-256 key); CNT_W = clog2(MAX_WORDS+1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request burst (sampled in IDLE only)
- cpol  in  1  SCLK idle level, latched at start
- cpha  in  1  0: sample leading/shift trailing; 1: shift leading/sample trailing; latched at start
- ss_sel  in  clog2(NUM_SS)  target slave, latched at start
- num_words  in  CNT_W  burst length, latched at start
- tx_data  in  DATA_W  next word to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  master accepts tx_data this cycle
- rx_data  out  DATA_W  last received word
- rx_valid  out  1  one-cycle pulse, rx_data new
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at burst end
- sclk  out  1  SPI clock
- mosi  out  1  SPI data out
- miso  in  1  SPI data in
- ss_n  out  NUM_SS  active-low selects

## Operation
- States: IDLE, LOAD, SETUP, SHIFT, HOLD.
- IDLE: sclk tracks registered cpol input; ss_n all ones; busy 0. Start accepted iff start=1, num_words in 1..MAX_WORDS, ss_sel<NUM_SS; otherwise ignored, no state change.
- Accept: latch mode/ss_sel/num_words, words_left=num_words, busy=1, ss_n[ss_sel]=0, go LOAD.
- LOAD: tx_ready=1 (only state where it is 1). tx_valid low -> wait indefinitely, sclk held at cpol, ss_n held low. On tx_valid&tx_ready: load shift register; CPHA=0 drives mosi=tx_data[DATA_W-1] immediately; go SETUP.
- SETUP: CLK_DIV cycles; then SHIFT.
- SHIFT: sclk toggles every CLK_DIV cycles, 2*DATA_W edges per word. Sample edges capture miso into rx shift reg; shift edges present next MSB on mosi (CPHA=1: first leading edge presents MSB).
- After final edge: rx_data updated, rx_valid pulse, words_left decremented. words_left>0 -> LOAD, sclk at cpol; else HOLD.
- HOLD: CLK_DIV cycles, then ss_n all ones, done pulse, busy 0, IDLE.
- start/cpol/cpha/ss_sel changes while busy have no effect.

## Timing
- Reset values: tx_ready 0, rx_data 0, rx_valid 0, busy 0, done 0, sclk 0, mosi 0, ss_n all ones; state IDLE.
- Reset mid-burst: all outputs return to reset values on the next edge; no done or rx_valid pulse; partial word discarded.
- Start sampled at edge T0: busy=1, ss_n low, tx_ready=1 from T0+1. tx_valid already high -> handshake at T0+1; first SCLK edge at T0+2+CLK_DIV.
- Word duration from first edge to last edge: (2*DATA_W-1)*CLK_DIV cycles; rx_valid one cycle after last edge.
- Back-to-back words with tx_valid held high: inter-word gap = 1 LOAD cycle + CLK_DIV setup cycles.
- done asserted CLK_DIV+1 cycles after the last word's rx_valid, with ss_n deasserting on the same edge; new start accepted the cycle after done.
- sclk, mosi and ss_n are registered outputs, glitch-free.

## Test plan
- Mode 0, DATA_W=8, CLK_DIV=2, miso looped to mosi, num_words=1, tx 0xA5 -> 16 sclk toggles, sclk idle 0, rx_data 0xA5, one rx_valid, one done, ss_n[0] low only during the burst.
- Modes 1, 2 and 3, slave model returns 0x3C while master sends 0xC3 -> rx_data 0x3C each time, sclk idle equals cpol, samples on the correct edge per cpha.
- Burst num_words=16 (AES-128 key bytes 0x00..0x0F), tx_valid dropped for 20 cycles before word 5 -> sclk frozen at cpol and ss_n held low during the stall, 16 rx_valid pulses, single done.
- Reset asserted mid-word 3 of a 4-word burst -> next cycle ss_n all ones, busy 0, sclk 0, no done; a fresh burst then completes normally.
- start with num_words=0, ss_sel=NUM_SS, and start pulsed while busy -> each ignored: busy unchanged and no extra done.
- NUM_SS=4 with ss_sel=2 -> only ss_n[2] goes low.
